// File: rtl/an_n29_pkg.sv
// Shared constants and types for the 6x6 AN-code (A=29) encoder.
package an_n29_pkg;

  localparam int A     = 29;
  localparam int ROWS  = 6;
  localparam int COLS  = 6;
  localparam int MW    = 10;
  localparam int CW    = 14;
  localparam int NSLOT = ROWS * COLS;
  localparam int CNTW  = 6;

  // Largest message whose product still fits in a codeword: floor((2^CW-1)/A) = 564.
  localparam logic [MW-1:0] MSG_MAX = MW'(((1 << CW) - 1) / A);

  typedef logic [CW-1:0] cw_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/an_encode_n29.sv
// Single-word AN encoder: cw = msg*29 via shift-add, zeroed when msg is out of range.
module an_encode_n29
  import an_n29_pkg::*;
(
  input  logic [MW-1:0] msg,
  output cw_t           cw,
  output logic          ovf
);

  logic [CW:0] m15;
  logic [CW:0] prod;

  // 29 = 16 + 8 + 4 + 1; the product is formed at 15 bits so 1023*29 cannot wrap.
  // Bit 14 can only be set by an out-of-range message, so folding it into ovf
  // changes nothing functionally and keeps every product bit observed.
  always_comb begin
    m15  = {{(CW + 1 - MW){1'b0}}, msg};
    prod = (m15 << 4) + (m15 << 3) + (m15 << 2) + m15;
    ovf  = (msg > MSG_MAX) | prod[CW];
    cw   = ovf ? '0 : prod[CW-1:0];
  end

endmodule

// File: rtl/an_encoder_n29_6x6.sv
// Collects 36 AN-encoded messages into a row-major 6x6 frame and hands it
// off under valid/ready.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FILL  | accepting messages; slot fill_cnt is written on each accept
//   FULL  | frame complete and held stable until frame_ready
module an_encoder_n29_6x6
  import an_n29_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MW-1:0]        in_msg,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [NSLOT*CW-1:0]  frame_cw,
  output logic                 frame_ovf,
  output logic [NSLOT-1:0]     ovf_mask,
  output logic [CNTW-1:0]      fill_cnt
);

  state_t state, state_next;
  cw_t    enc_cw;
  logic   enc_ovf;
  logic   accept;
  logic   release_frame;
  cw_t    slot [NSLOT];

  an_encode_n29 u_enc (
    .msg (in_msg),
    .cw  (enc_cw),
    .ovf (enc_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // Next state and handshake outputs; in_ready depends on state only, so the
  // release cycle cannot also accept a message.
  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    frame_valid   = 1'b0;
    accept        = 1'b0;
    release_frame = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && fill_cnt == CNTW'(NSLOT - 1)) state_next = FULL;
      end
      FULL: begin
        frame_valid   = 1'b1;
        release_frame = frame_ready;
        if (release_frame) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Fill counter, per-slot overflow mask and its OR, cleared on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      ovf_mask  <= '0;
      frame_ovf <= 1'b0;
    end else if (release_frame) begin
      fill_cnt  <= '0;
      ovf_mask  <= '0;
      frame_ovf <= 1'b0;
    end else if (accept) begin
      fill_cnt  <= fill_cnt + CNTW'(1);
      frame_ovf <= frame_ovf | enc_ovf;
      for (int k = 0; k < NSLOT; k++) begin
        if (fill_cnt == CNTW'(k)) ovf_mask[k] <= enc_ovf;
      end
    end
  end

  // Slot register file; slots keep old contents across release until rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLOT; k++) slot[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (fill_cnt == CNTW'(k)) slot[k] <= enc_cw;
      end
    end
  end

  // Flatten slots onto the frame bus, slot k at bits [k*CW +: CW].
  always_comb begin
    frame_cw = '0;
    for (int k = 0; k < NSLOT; k++) frame_cw[k*CW +: CW] = slot[k];
  end

endmodule

// File: tb/tb_an_encoder_n29_6x6.sv
// Directed bench for the 6x6 AN-code encoder frame builder.
module tb_an_encoder_n29_6x6;

  localparam int CW    = 14;
  localparam int NSLOT = 36;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [9:0]          in_msg;
  logic                frame_valid;
  logic                frame_ready;
  logic [NSLOT*CW-1:0] frame_cw;
  logic                frame_ovf;
  logic [NSLOT-1:0]    ovf_mask;
  logic [5:0]          fill_cnt;

  int checks   = 0;
  int failures = 0;

  logic [NSLOT*CW-1:0] exp_vec;
  logic [NSLOT-1:0]    exp_mask;
  int                  msgs [NSLOT];

  an_encoder_n29_6x6 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_msg      (in_msg),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_cw    (frame_cw),
    .frame_ovf   (frame_ovf),
    .ovf_mask    (ovf_mask),
    .fill_cnt    (fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] enc_model(input int m);
    if (m > 564) return '0;
    return CW'(m * 29);
  endfunction

  function automatic logic [CW-1:0] slot_of(input int k);
    return frame_cw[k*CW +: CW];
  endfunction

  // Present one message for one edge, then check shortly after that edge.
  task automatic send(input int m);
    in_valid = 1'b1;
    in_msg   = 10'(m);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic build_expect();
    exp_vec  = '0;
    exp_mask = '0;
    for (int k = 0; k < NSLOT; k++) begin
      exp_vec[k*CW +: CW] = enc_model(msgs[k]);
      exp_mask[k]         = (msgs[k] > 564);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_msg      = '0;
    frame_ready = 1'b1;
    #12;
    chk("rst_fill_cnt", fill_cnt, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_cw_zero", frame_cw == '0, 1);
    chk("rst_ovf_mask", ovf_mask, 0);
    chk("rst_frame_ovf", frame_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Frame 1: messages 0..35 back to back, consumer always ready.
    for (int k = 0; k < NSLOT; k++) begin
      msgs[k] = k;
      send(k);
      if (k == 9) chk("f1_fill_cnt_10", fill_cnt, 10);
      if (k < NSLOT - 1) chk("f1_not_valid_early", frame_valid, 0);
    end
    build_expect();
    chk("f1_frame_valid", frame_valid, 1);
    chk("f1_in_ready_low", in_ready, 0);
    chk("f1_fill_cnt_36", fill_cnt, 36);
    chk("f1_slot35", slot_of(35), 1015);
    chk("f1_slot1", slot_of(1), 29);
    chk("f1_frame_cw", frame_cw == exp_vec, 1);
    chk("f1_frame_ovf", frame_ovf, 0);
    @(posedge clk);
    #1;
    chk("f1_released", frame_valid, 0);
    chk("f1_fill_cnt_0", fill_cnt, 0);
    chk("f1_in_ready_back", in_ready, 1);

    // Frame 2: range boundary plus backpressure.
    frame_ready = 1'b0;
    for (int k = 0; k < NSLOT; k++) msgs[k] = 3 * k + 100;
    msgs[0]  = 564;
    msgs[7]  = 565;
    msgs[20] = 1023;
    for (int k = 0; k < NSLOT; k++) send(msgs[k]);
    build_expect();
    chk("f2_frame_valid", frame_valid, 1);
    chk("f2_slot0", slot_of(0), 16356);
    chk("f2_slot7", slot_of(7), 0);
    chk("f2_slot20", slot_of(20), 0);
    chk("f2_mask0", ovf_mask[0], 0);
    chk("f2_mask7", ovf_mask[7], 1);
    chk("f2_mask20", ovf_mask[20], 1);
    chk("f2_ovf_mask", ovf_mask, exp_mask);
    chk("f2_frame_ovf", frame_ovf, 1);
    chk("f2_frame_cw", frame_cw == exp_vec, 1);

    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_msg   = 10'(i * 37 + 5);
      @(posedge clk);
      #1;
      chk("hold_cw", frame_cw == exp_vec, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_fill_cnt", fill_cnt, 36);
      chk("hold_valid", frame_valid, 1);
    end
    chk("hold_mask", ovf_mask, exp_mask);
    chk("hold_frame_ovf", frame_ovf, 1);

    // Release with in_valid held high: no accept during the release cycle.
    in_msg      = 10'd100;
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    chk("rel_valid", frame_valid, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_fill_cnt", fill_cnt, 0);
    chk("rel_mask", ovf_mask, 0);
    chk("rel_frame_ovf", frame_ovf, 0);
    chk("rel_slot0_kept", slot_of(0), 16356);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_rel_fill_cnt", fill_cnt, 1);
    chk("post_rel_slot0", slot_of(0), 2900);

    // Nine more accepts (ten total), one out of range, then async reset mid-cycle.
    for (int k = 1; k < 10; k++) send((k == 4) ? 700 : k + 50);
    chk("pre_rst_fill_cnt", fill_cnt, 10);
    chk("pre_rst_mask4", ovf_mask[4], 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_fill_cnt", fill_cnt, 0);
    chk("arst_valid", frame_valid, 0);
    chk("arst_mask", ovf_mask, 0);
    chk("arst_frame_ovf", frame_ovf, 0);
    chk("arst_frame_cw_zero", frame_cw == '0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh random frame; decode each slot back to its message.
    frame_ready = 1'b1;
    for (int k = 0; k < NSLOT; k++) begin
      msgs[k] = int'($urandom_range(0, 564));
      send(msgs[k]);
    end
    build_expect();
    chk("f3_frame_valid", frame_valid, 1);
    chk("f3_frame_ovf", frame_ovf, 0);
    chk("f3_frame_cw", frame_cw == exp_vec, 1);
    for (int k = 0; k < NSLOT; k++) begin
      chk("loop_residue", 32'(slot_of(k)) % 29, 0);
      chk("loop_decode", 32'(slot_of(k)) / 29, msgs[k]);
    end
    @(posedge clk);
    #1;
    chk("f3_released", frame_valid, 0);
    chk("f3_fill_cnt_0", fill_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/an_encoder_n29_6x6.md
Name: an_encoder_n29_6x6

Overview:
- Transmit-side counterpart of the 6x6 AN-code (A=29) decoder array.
- Accepts a stream of 10-bit messages, encodes each as codeword = message*29 (14-bit), and assembles 36 codewords into a row-major 6x6 frame.
- Slot k is at row k/6, column k%6, matching decoder output index k.
- Holds the completed frame on a flat output bus under a valid/ready handshake, so every element is checkable by the downstream barrett_n29 row/column error-location array.

Parameters:
- A, 29, AN multiplier constant.
- ROWS, 6, frame rows.
- COLS, 6, frame columns.
- MW, 10, message width.
- CW, 14, codeword width.
- MSG_MAX, 564, largest encodable message: floor((2^CW-1)/A).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  message available.
- in_ready  out  1  block accepts a message this cycle.
- in_msg  in  MW  message value.
- frame_valid  out  1  complete 36-codeword frame held on frame_cw.
- frame_ready  in  1  consumer takes the frame.
- frame_cw  out  ROWS*COLS*CW (504)  slot k in bits [k*CW +: CW].
- frame_ovf  out  1  at least one message in the held frame exceeded MSG_MAX.
- ovf_mask  out  ROWS*COLS (36)  bit k set when slot k's message exceeded MSG_MAX.
- fill_cnt  out  6  slots written in the current frame, 0..36.

Behaviour:
- Clock/reset: one clock domain. Reset is asynchronous and active-low: rst_n=0 immediately clears all state.
- Reset values: state=FILL, fill_cnt=0, in_ready=1 after reset release, frame_valid=0, frame_cw=0, ovf_mask=0, frame_ovf=0.
- States:
  - FILL: in_ready=1, frame_valid=0.
  - FULL: in_ready=0, frame_valid=1.
- Accept: in_valid & in_ready at edge t writes slot fill_cnt at that edge; fill_cnt increments.
- Encoding:
  - Result is (m<<4)+(m<<3)+(m<<2)+m, computed at 15 bits, registered directly into the slot. No extra pipeline stage; latency from accept to slot update is 1 edge.
  - If m>MSG_MAX: slot is written as 0 and ovf_mask[k] is set. 0 is a valid codeword, so the decoder sees no error; the flag carries the fault instead.
  - Otherwise ovf_mask[k] is cleared.
- FILL->FULL: on the accept that writes slot 35 (fill_cnt 35->36). frame_valid=1 from the next cycle.
- FULL hold: frame_cw, ovf_mask and frame_ovf remain stable while frame_valid & !frame_ready. in_msg and in_valid are ignored.
- FULL->FILL: on frame_valid & frame_ready.
  - fill_cnt->0, ovf_mask->0, frame_ovf->0.
  - frame_cw retains its old contents until overwritten; slots are not cleared.
  - in_ready=1 from the next cycle. There is no same-cycle bypass: in_ready=0 during the release cycle even if in_valid=1.
- frame_ovf = OR of ovf_mask. Registered together with the mask, so it is valid whenever frame_valid=1.
- Partial frames: no flush or timeout. A partial frame stays in FILL indefinitely.
- in_valid with in_ready=0: no state change.
- Reset mid-frame or while FULL: the partial or held frame is discarded, all outputs return to reset values, and no frame_valid pulse is produced.

Decomposition:
- Package an_n29_pkg holds:
  - A, MW, CW, MSG_MAX, ROWS, COLS;
  - localparam NSLOT=36;
  - a typedef for the codeword word;
  - the state enum {FILL, FULL}.
- One natural sub-module: an_encode_n29. Combinational, takes msg; outputs cw and ovf; contains the shift-add and the range compare. Reusable by single-word encoder paths.
- The top holds the counter, FSM, the 36-entry slot register file and ovf_mask.

Test Plan:
- Send messages 0..35 back-to-back with frame_ready=1 -> frame_valid rises 1 cycle after the 36th accept; slot k=29k (slot 35=1015); frame_ovf=0; released next cycle; fill_cnt=0.
- Message 564 in slot 0 and 565 in slot 7 -> slot0=16356, ovf_mask[0]=0; slot7=0, ovf_mask[7]=1; frame_ovf=1. Message 1023 -> slot=0, mask bit set.
- Backpressure: full frame with frame_ready=0 for 20 cycles while in_valid=1 and in_msg changes -> frame_cw constant, in_ready=0, no accepts; frame_ready=1 -> release, in_ready=1 next cycle.
- Release cycle with in_valid=1 -> in_valid is not accepted that cycle; the message is accepted the following cycle into slot 0.
- Assert rst_n=0 asynchronously mid-cycle after 10 accepts -> fill_cnt=0, frame_valid=0, ovf_mask=0 immediately. A fresh 36-message frame then completes normally.
- Loopback through the 6x6 decoder array with random messages <=564 -> decoder OUTk equals the sent message k for all 36 slots.
